// File: rtl/ir_sensor_emulator.sv
// IR reflectance sensor (RC-decay type) emulator.
// Watches the host's charge pulse on a shared open line, then holds the line
// high for a programmable decay time and actively pulls it low for a short
// tail, so the host's measured count tracks decay_count.

// Two-flop input synchronizer, enabled by clock_valid, cleared by reset.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clock_valid,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // Two register stages between the asynchronous line and the FSM.
    always_ff @(posedge clock) begin
        if (clock_valid) begin
            if (reset) begin
                meta <= '0;
                dout <= '0;
            end else begin
                // NOTE: non-blocking assignments let both stages sample their
                // old values on the same edge; blocking would collapse the
                // pipeline into one stage.
                meta <= din;
                dout <= meta;
            end
        end
    end

endmodule

module ir_sensor_emulator #(
    parameter logic [18:0] MIN_CHARGE  = 19'd500,
    parameter logic [18:0] MAX_DECAY   = 19'd300000,
    parameter logic [3:0]  TAIL_CYCLES = 4'd2
) (
    input  logic        clock,
    input  logic        clock_valid,
    input  logic        reset,
    input  logic [18:0] decay_count,
    inout  wire         sensor_line,
    output logic [18:0] last_charge,
    output logic        cycle_done,
    output logic        charge_error,
    output logic        active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        DECAY  = 2'd2,
        TAIL   = 2'd3
    } state_t;

    localparam logic [18:0] CNT_MAX = 19'h7FFFF;

    state_t      state;
    logic [18:0] cnt;
    logic [18:0] dcnt;
    logic [3:0]  tcnt;
    logic        drive_en;
    logic        drive_val;
    logic        line_sync;
    logic [18:0] decay_clamped;

    // Tristate driver: enable and data both come straight from registers,
    // so no input can reach the line combinationally.
    assign sensor_line = drive_en ? drive_val : 1'bz;

    // Decay length is clamped so a bad register value cannot stall the host.
    assign decay_clamped = (decay_count > MAX_DECAY) ? MAX_DECAY : decay_count;

    synchronizer #(.WIDTH(1)) u_sync (
        .clock       (clock),
        .clock_valid (clock_valid),
        .reset       (reset),
        .din         (sensor_line),
        .dout        (line_sync)
    );

    // Charge/decay/tail sequencer with registered line drive and status pulses.
    always_ff @(posedge clock) begin
        if (clock_valid) begin
            if (reset) begin
                state        <= IDLE;
                cnt          <= '0;
                dcnt         <= '0;
                tcnt         <= '0;
                drive_en     <= 1'b0;
                drive_val    <= 1'b0;
                last_charge  <= '0;
                cycle_done   <= 1'b0;
                charge_error <= 1'b0;
                active       <= 1'b0;
            end else begin
                cycle_done   <= 1'b0;
                charge_error <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (line_sync) begin
                            state <= CHARGE;
                            cnt   <= 19'd1;
                        end
                    end
                    CHARGE: begin
                        if (line_sync) begin
                            if (cnt != CNT_MAX) cnt <= cnt + 19'd1;
                        end else if (cnt >= MIN_CHARGE) begin
                            last_charge <= cnt;
                            active      <= 1'b1;
                            drive_en    <= 1'b1;
                            tcnt        <= '0;
                            if (decay_clamped == 19'd0) begin
                                // Zero decay skips the high phase entirely.
                                state     <= TAIL;
                                drive_val <= 1'b0;
                            end else begin
                                state     <= DECAY;
                                dcnt      <= decay_clamped;
                                drive_val <= 1'b1;
                            end
                        end else begin
                            state        <= IDLE;
                            charge_error <= 1'b1;
                        end
                    end
                    DECAY: begin
                        // The line went high on entry, so the last high cycle
                        // is the one where dcnt reaches 1; this gives exactly
                        // decay_clamped high cycles with a registered output.
                        if (dcnt <= 19'd1) begin
                            state     <= TAIL;
                            dcnt      <= '0;
                            tcnt      <= '0;
                            drive_val <= 1'b0;
                        end else begin
                            dcnt <= dcnt - 19'd1;
                        end
                    end
                    TAIL: begin
                        if (tcnt + 4'd1 >= TAIL_CYCLES) begin
                            state      <= IDLE;
                            tcnt       <= '0;
                            drive_en   <= 1'b0;
                            drive_val  <= 1'b0;
                            active     <= 1'b0;
                            cycle_done <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                    // NOTE: the default arm keeps the state register on a
                    // legal encoding even if it is ever corrupted.
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
